// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the ARM data-memory responder slice.
//   resp_state_t      : responder FSM state encoding (IDLE, WAIT, RESP)
//   MMIO_ADDR_DEFAULT : default byte address of the result register
//   DEPTH_DEFAULT     : default RAM size in 32-bit words
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

    localparam logic [31:0] MMIO_ADDR_DEFAULT = 32'h0000_0100;
    localparam int unsigned DEPTH_DEFAULT     = 64;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request/response bus between the core (master) and the
// data-memory responder (slave).
//   req, we, addr, wdata : request, driven by the master
//   ready, rdata, err    : one-cycle response, driven by the slave
interface dmem_responder_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata, err
    );

endinterface

// File: rtl/dmem_responder_ram.sv
// DEPTH x 32 word array for the data-memory responder. No reset.
//   clk   : clock
//   en    : access enable (asserted on the edge entering RESP)
//   we    : 1 = write wdata, 0 = register word into rdata
//   idx   : word index
//   wdata : write data
//   rdata : registered read data
module dmem_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked, wait-stated data-memory slave for the ARM core's load/store
// port, with one memory-mapped result register.
//   clk, reset : clock; asynchronous active-high reset
//   bus        : slave side of the request/response bus
//   done       : sticky, set by any store to MMIO_ADDR
//   result     : last value stored to MMIO_ADDR
//   txn_count  : completed transactions (including faulted), wrapping
module dmem_responder
    import arm_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = DEPTH_DEFAULT,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] MMIO_ADDR   = MMIO_ADDR_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    dmem_responder_if.slave     bus,
    output logic                done,
    output logic [31:0]         result,
    output logic [15:0]         txn_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_state_t state;
    logic [3:0]  wcnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        sel_ram;
    logic [31:0] rdata_q;
    logic [31:0] ram_rdata;

    logic        enter_resp;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        ram_hit;
    logic        mmio_hit;

    always_comb begin
        // With zero wait states the access happens on the accept edge itself,
        // before the request registers load, so decode straight off the bus.
        if (state == IDLE) begin
            acc_we    = bus.we;
            acc_addr  = bus.addr;
            acc_wdata = bus.wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        enter_resp = ((state == IDLE) && bus.req && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (wcnt == '0));
        ram_hit  = (acc_addr[1:0] == 2'b00) && ({2'b00, acc_addr[31:2]} < DEPTH);
        mmio_hit = (acc_addr == MMIO_ADDR);
    end

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (enter_resp && ram_hit),
        .we    (acc_we),
        .idx   (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // RAM load data comes from the RAM's own read register; MMIO loads and
    // faults/stores come from rdata_q.
    always_comb begin
        bus.rdata = sel_ram ? ram_rdata : rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wcnt      <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            bus.ready <= 1'b0;
            bus.err   <= 1'b0;
            sel_ram   <= 1'b0;
            rdata_q   <= '0;
            done      <= 1'b0;
            result    <= '0;
            txn_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            wcnt  <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (wcnt == '0) begin
                        state <= RESP;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    bus.ready <= 1'b0;
                    txn_count <= txn_count + 16'd1;
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                bus.ready <= 1'b1;
                bus.err   <= !(ram_hit || mmio_hit);
                sel_ram   <= ram_hit && !acc_we;
                rdata_q   <= (mmio_hit && !acc_we) ? result : '0;
                if (mmio_hit && acc_we) begin
                    result <= acc_wdata;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: instance 0 uses two wait states,
// instance 1 uses zero. Expected responses come from a word-array model and
// are queued at issue time; a monitor pops them on every ready pulse.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst0, rst1;
    logic        done0, done1;
    logic [31:0] res0, res1;
    logic [15:0] cnt0, cnt1;

    dmem_responder_if if0 ();
    dmem_responder_if if1 ();

    dmem_responder #(.WAIT_CYCLES(2)) dut0 (
        .clk       (clk),
        .reset     (rst0),
        .bus       (if0),
        .done      (done0),
        .result    (res0),
        .txn_count (cnt0)
    );

    dmem_responder #(.WAIT_CYCLES(0)) dut1 (
        .clk       (clk),
        .reset     (rst1),
        .bus       (if1),
        .done      (done1),
        .result    (res1),
        .txn_count (cnt1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned cyc;
        logic [31:0] rdata;
        logic        err;
        logic        done;
        logic [31:0] result;
        logic [15:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: plain word memory plus result/done/count per instance.
    logic [31:0] mram [2][64];
    logic [31:0] mres [2];
    logic        mdone [2];
    logic [15:0] mcnt [2];
    bit          held [2];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model_txn(int inst, logic we, logic [31:0] a,
                                       logic [31:0] wd, int unsigned acc);
        exp_t e;
        e.cyc   = acc + ((inst == 0) ? 2 : 0);
        e.rdata = 32'd0;
        e.err   = 1'b0;
        if (a == 32'h100) begin
            if (we) begin
                mres[inst]  = wd;
                mdone[inst] = 1'b1;
            end else begin
                e.rdata = mres[inst];
            end
        end else if ((a % 4 == 0) && (a / 4 < 64)) begin
            if (we) mram[inst][a / 4] = wd;
            else    e.rdata = mram[inst][a / 4];
        end else begin
            e.err = 1'b1;
        end
        e.done   = mdone[inst];
        e.result = mres[inst];
        e.cnt    = mcnt[inst];
        mcnt[inst] = mcnt[inst] + 16'd1;
        return e;
    endfunction

    task automatic drive(int inst, logic r, logic w, logic [31:0] a, logic [31:0] d);
        if (inst == 0) begin
            if0.req = r; if0.we = w; if0.addr = a; if0.wdata = d;
        end else begin
            if1.req = r; if1.we = w; if1.addr = a; if1.wdata = d;
        end
    endtask

    function automatic logic rdy(int inst);
        return (inst == 0) ? if0.ready : if1.ready;
    endfunction

    // Issue one transaction. When req was kept high from the previous one,
    // this is called on that response's cycle and the next accept is two
    // edges later; otherwise the DUT is idle and accepts at the next edge.
    task automatic txn(int inst, logic we, logic [31:0] a, logic [31:0] wd, bit keep);
        int unsigned acc;
        bit got;
        if (!held[inst]) begin
            @(negedge clk);
            acc = cyc + 1;
        end else begin
            acc = cyc + 2;
        end
        drive(inst, 1'b1, we, a, wd);
        if (inst == 0) q0.push_back(model_txn(inst, we, a, wd, acc));
        else           q1.push_back(model_txn(inst, we, a, wd, acc));
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy(inst)) begin
                got = 1'b1;
                break;
            end
            if (cyc >= acc)
                drive(inst, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL d%0d ready timeout: got no ready expected ready within 50 cycles", inst);
        end
        held[inst] = keep;
        if (!keep) drive(inst, 1'b0, 1'b0, $urandom, $urandom);
    endtask

    task automatic mon(int inst, logic [31:0] rd, logic er, logic dn,
                       logic [31:0] rs, logic [15:0] tc);
        exp_t e;
        if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL d%0d unexpected ready: got ready=1 expected no response", inst);
            return;
        end
        if (inst == 0) e = q0.pop_front();
        else           e = q1.pop_front();
        chk($sformatf("d%0d resp cycle", inst), cyc, e.cyc);
        chk($sformatf("d%0d rdata", inst), rd, e.rdata);
        chk($sformatf("d%0d err", inst), 32'(er), 32'(e.err));
        chk($sformatf("d%0d done", inst), 32'(dn), 32'(e.done));
        chk($sformatf("d%0d result", inst), rs, e.result);
        chk($sformatf("d%0d txn_count", inst), 32'(tc), 32'(e.cnt));
    endtask

    always @(negedge clk) begin
        if (if0.ready) mon(0, if0.rdata, if0.err, done0, res0, cnt0);
        if (if1.ready) mon(1, if1.rdata, if1.err, done1, res1, cnt1);
    end

    task automatic rchk(int inst);
        if (inst == 0) begin
            chk("d0 reset ready", 32'(if0.ready), 32'd0);
            chk("d0 reset err", 32'(if0.err), 32'd0);
            chk("d0 reset rdata", if0.rdata, 32'd0);
            chk("d0 reset done", 32'(done0), 32'd0);
            chk("d0 reset result", res0, 32'd0);
            chk("d0 reset txn_count", 32'(cnt0), 32'd0);
        end else begin
            chk("d1 reset ready", 32'(if1.ready), 32'd0);
            chk("d1 reset err", 32'(if1.err), 32'd0);
            chk("d1 reset rdata", if1.rdata, 32'd0);
            chk("d1 reset done", 32'(done1), 32'd0);
            chk("d1 reset result", res1, 32'd0);
            chk("d1 reset txn_count", 32'(cnt1), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            mres[i] = '0; mdone[i] = 1'b0; mcnt[i] = '0; held[i] = 1'b0;
        end
        rst0 = 1'b1;
        rst1 = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        rchk(0);
        rchk(1);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Store then load through the wait-stated instance.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 1'b0);
        @(negedge clk);
        chk("d0 txn_count after store/load", 32'(cnt0), 32'd2);

        for (int i = 0; i < 64; i++)
            txn(0, 1'b1, 32'(i * 4), $urandom, 1'b0);

        // Result register, then confirm every RAM word is untouched.
        txn(0, 1'b1, 32'h100, 32'd2560, 1'b0);
        txn(0, 1'b0, 32'h100, 32'h0, 1'b0);
        for (int i = 0; i < 64; i++)
            txn(0, 1'b0, 32'(i * 4), $urandom, 1'b0);

        // Faults leave memory alone.
        txn(0, 1'b1, 32'h13, 32'hCAFEF00D, 1'b0);
        txn(0, 1'b1, 32'h200, 32'hCAFEF00D, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 1'b0);

        // Reset while in WAIT abandons the store.
        txn(0, 1'b1, 32'h8, 32'h0, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h8, 32'h1234);
        @(negedge clk);
        rst0 = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        #1;
        rchk(0);
        mres[0] = '0; mdone[0] = 1'b0; mcnt[0] = '0;
        @(negedge clk);
        rst0 = 1'b0;
        repeat (6) @(negedge clk);
        txn(0, 1'b0, 32'h8, 32'h0, 1'b0);

        // Randomized mix.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 63) * 4);
                6:       a = 32'h100;
                7:       a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
                8:       a = 32'h200 + 32'($urandom_range(0, 100) * 4);
                default: a = $urandom;
            endcase
            txn(0, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
        end
        @(negedge clk);
        chk("d0 final txn_count", 32'(cnt0), 32'(mcnt[0]));

        // Zero wait states, req held high across alternating loads.
        txn(1, 1'b1, 32'h0, 32'h11111111, 1'b0);
        txn(1, 1'b1, 32'h4, 32'h22222222, 1'b0);
        for (int i = 0; i < 10; i++)
            txn(1, 1'b0, (i % 2 == 1) ? 32'h4 : 32'h0, 32'h0, i < 9);

        // Counter wrap from a forced all-ones value.
        @(negedge clk);
        force dut1.txn_count = 16'hFFFF;
        @(negedge clk);
        release dut1.txn_count;
        mcnt[1] = 16'hFFFF;
        @(negedge clk);
        chk("d1 txn_count preset", 32'(cnt1), 32'h0000FFFF);
        txn(1, 1'b0, 32'h4, 32'h0, 1'b0);
        @(negedge clk);
        chk("d1 txn_count wrap", 32'(cnt1), 32'h00000000);

        repeat (4) @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending responses: got %0d/%0d outstanding expected 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
